// File: rtl/alu_sequencer.sv
// Multicycle add/subtract/multiply controller. Add/sub finish in one execute cycle.
// Multiply is a shift-add over NBITS cycles. Result, overflow and 7-segment code are held afterwards.
module alu_sequencer #(
    parameter int NBITS = 3,
    parameter int RBITS = 2 * NBITS
) (
    input  logic             clk_2,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [RBITS-1:0] result,
    output logic             ovf,
    output logic [7:0]       seg
);

    localparam int CW = $clog2(NBITS + 1);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              op_q, op_d;
    logic signed [NBITS-1:0] a_q, a_d, b_q, b_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [RBITS-1:0]        mcand_q, mcand_d;
    logic [NBITS-1:0]        mplier_q, mplier_d;
    logic [RBITS-1:0]        acc_q, acc_d;
    logic [RBITS-1:0]        result_q, result_d;
    logic                    res_signed_q, res_signed_d;
    logic                    ovf_q, ovf_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;

    logic signed [NBITS:0]   a_ext, b_ext, sum;
    logic [RBITS-1:0]        acc_nxt;
    logic                    neg;

    // |-2^(NBITS-1)| still fits in NBITS unsigned bits.
    function automatic logic [NBITS-1:0] magnitude(input logic signed [NBITS-1:0] v,
                                                   input logic is_signed);
        if (is_signed && v[NBITS-1]) return NBITS'(-v);
        return v;
    endfunction

    function automatic logic [RBITS-1:0] sext_sum(input logic signed [NBITS:0] s);
        return RBITS'(s);
    endfunction

    function automatic logic [7:0] seg_code(input logic [RBITS-1:0] r, input logic is_signed);
        int v;
        if (is_signed) v = int'($signed(r));
        else           v = int'(r);
        case (v)
            0:       return 8'b0011_1111;
            1:       return 8'b0000_0110;
            2:       return 8'b0101_1011;
            3:       return 8'b0100_1111;
            -1:      return 8'b1000_0110;
            -2:      return 8'b1101_1011;
            -3:      return 8'b1100_1111;
            -4:      return 8'b1110_0110;
            default: return 8'b1000_0000;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        acc_d        = acc_q;
        result_d     = result_q;
        res_signed_d = res_signed_q;
        ovf_d        = ovf_q;
        done_d       = 1'b0;

        a_ext   = (NBITS+1)'(a_q);
        b_ext   = (NBITS+1)'(b_q);
        sum     = op_q[0] ? (a_ext - b_ext) : (a_ext + b_ext);
        acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
        neg     = op_q[0] & (a_q[NBITS-1] ^ b_q[NBITS-1]);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = op;
                    a_d  = a;
                    b_d  = b;
                    if (op[1]) begin
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = RBITS'(magnitude(a, op[0]));
                        mplier_d = magnitude(b, op[0]);
                        state_d  = MUL;
                    end else begin
                        state_d  = EXEC;
                    end
                end
            end
            EXEC: begin
                result_d     = sext_sum(sum);
                res_signed_d = 1'b1;
                ovf_d        = sum[NBITS] ^ sum[NBITS-1];
                done_d       = 1'b1;
                state_d      = DONE;
            end
            MUL: begin
                acc_d    = acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(NBITS - 1)) begin
                    result_d     = neg ? (~acc_nxt + RBITS'(1)) : acc_nxt;
                    res_signed_d = op_q[0];
                    ovf_d        = 1'b0;
                    done_d       = 1'b1;
                    state_d      = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cnt_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            result_q     <= '0;
            res_signed_q <= 1'b1;
            ovf_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            acc_q        <= acc_d;
            result_q     <= result_d;
            res_signed_q <= res_signed_d;
            ovf_q        <= ovf_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    // seg follows the interpretation of the op that produced result, not the op latched since.
    assign seg    = seg_code(result_q, res_signed_q);
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign ovf    = ovf_q;

endmodule
